// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_pkg
// Brief    : Shared lane-count, count type and packer state encoding.
// Revision : 1.0
// ============================================================================
package maxpool_pkg;

   localparam int UNITS_DEF  = 2;
   localparam int GROUPS_DEF = 2;
   localparam int N          = GROUPS_DEF * UNITS_DEF * 2;
   localparam int CNT_W      = $clog2(N + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/maxpool_keep_compactor.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_keep_compactor
// Brief    : Combinational compaction of kept lanes to the low end + popcount.
// Revision : 1.0
// ============================================================================
module maxpool_keep_compactor
   import maxpool_pkg::*;
#(
   parameter int LANES      = 8,
   parameter int WORD_WIDTH = 8,
   parameter int CW         = $clog2(LANES + 1)
)(
   input  logic [LANES*WORD_WIDTH-1:0] i_data,
   input  logic [LANES-1:0]            i_keep,
   output logic [LANES*WORD_WIDTH-1:0] o_data,
   output logic [CW-1:0]               o_count
);

   int w_pos;

   // Running prefix count selects the destination slot of each kept lane.
   always_comb begin
      o_data = '0;
      w_pos  = 0;
      for (int i = 0; i < LANES; i++) begin
         if (i_keep[i]) begin
            o_data[w_pos*WORD_WIDTH +: WORD_WIDTH] = i_data[i*WORD_WIDTH +: WORD_WIDTH];
            w_pos = w_pos + 1;
         end
      end
      o_count = CW'(w_pos);
   end

endmodule
`default_nettype wire

// File: rtl/maxpool_output_packer.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_output_packer
// Brief    : Packs sparse maxpool lanes into dense full-width beats for DMA.
//            MAXPOOL_PACKER_WCOUNT_EN adds the m_packet_words word counter.
// Revision : 1.0
// ============================================================================
module maxpool_output_packer
   import maxpool_pkg::*;
#(
   parameter int UNITS      = 2,
   parameter int GROUPS     = 2,
   parameter int WORD_WIDTH = 8
)(
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic                                   clken,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   input  logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]   s_data_flat,
   input  logic [GROUPS*UNITS*2-1:0]              s_keep_flat,
   input  logic                                   s_last,
   output logic                                   m_valid,
   input  logic                                   m_ready,
   output logic [GROUPS*UNITS*2*WORD_WIDTH-1:0]   m_data_flat,
   output logic [GROUPS*UNITS*2-1:0]              m_keep_flat,
`ifdef MAXPOOL_PACKER_WCOUNT_EN
   output logic [31:0]                            m_packet_words,
`endif
   output logic                                   m_last
);

   localparam int LANES = GROUPS * UNITS * 2;
   localparam int DW    = LANES * WORD_WIDTH;
   localparam int CW    = $clog2(LANES + 1);
   localparam int SW    = $clog2(2 * LANES + 1);

   state_t           r_state, w_nxt_state;
   logic [CW-1:0]    r_cnt, w_nxt_cnt;
   logic [DW-1:0]    r_acc, w_nxt_acc;
   logic             r_m_valid, w_nxt_valid;
   logic             r_m_last, w_nxt_last;
   logic [DW-1:0]    r_m_data, w_nxt_data;
   logic [LANES-1:0] r_m_keep, w_nxt_keep;

   logic [DW-1:0]    w_cdata;
   logic [CW-1:0]    w_pc;
   logic [SW-1:0]    w_sum;
   logic [2*DW-1:0]  w_comb;
   logic             w_s_ready, w_accept, w_out_hs;

   maxpool_keep_compactor #(
      .LANES      (LANES),
      .WORD_WIDTH (WORD_WIDTH),
      .CW         (CW)
   ) u_compactor (
      .i_data  (s_data_flat),
      .i_keep  (s_keep_flat),
      .o_data  (w_cdata),
      .o_count (w_pc)
   );

   function automatic logic [LANES-1:0] keep_mask(input logic [CW-1:0] k);
      logic [LANES:0] t;
      t = ((LANES+1)'(1) << k) - 1'b1;
      return t[LANES-1:0];
   endfunction

   // Accumulator is kept zero above r_cnt, so OR-ing in the shifted words is exact.
   assign w_sum     = SW'(r_cnt) + SW'(w_pc);
   assign w_comb    = {{DW{1'b0}}, r_acc} | ({{DW{1'b0}}, w_cdata} << (r_cnt * WORD_WIDTH));
   assign w_s_ready = (r_state == ACCUM) && (!r_m_valid || m_ready);
   assign w_accept  = s_valid && w_s_ready;
   assign w_out_hs  = r_m_valid && m_ready;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_acc   = r_acc;
      w_nxt_valid = r_m_valid && !w_out_hs;
      w_nxt_data  = r_m_data;
      w_nxt_keep  = r_m_keep;
      w_nxt_last  = r_m_last;
      case (r_state)
         ACCUM: begin
            if (w_accept) begin
               if (w_sum >= SW'(LANES)) begin
                  w_nxt_valid = 1'b1;
                  w_nxt_data  = w_comb[DW-1:0];
                  w_nxt_keep  = '1;
                  w_nxt_last  = s_last && (w_sum == SW'(LANES));
                  w_nxt_acc   = w_comb[2*DW-1:DW];
                  w_nxt_cnt   = CW'(w_sum - SW'(LANES));
                  if (s_last && (w_sum > SW'(LANES)))
                     w_nxt_state = FLUSH;
               end else if (s_last) begin
                  w_nxt_valid = 1'b1;
                  w_nxt_data  = w_comb[DW-1:0];
                  w_nxt_keep  = keep_mask(CW'(w_sum));
                  w_nxt_last  = 1'b1;
                  w_nxt_acc   = '0;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_acc   = w_comb[DW-1:0];
                  w_nxt_cnt   = CW'(w_sum);
               end
            end
         end
         FLUSH: begin
            if (w_out_hs) begin
               w_nxt_valid = 1'b1;
               w_nxt_data  = r_acc;
               w_nxt_keep  = keep_mask(r_cnt);
               w_nxt_last  = 1'b1;
               w_nxt_acc   = '0;
               w_nxt_cnt   = '0;
               w_nxt_state = ACCUM;
            end
         end
         default: w_nxt_state = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ACCUM;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_keep  <= '0;
         r_m_last  <= 1'b0;
      end else if (clken) begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_acc     <= w_nxt_acc;
         r_m_valid <= w_nxt_valid;
         r_m_data  <= w_nxt_data;
         r_m_keep  <= w_nxt_keep;
         r_m_last  <= w_nxt_last;
      end
   end

`ifdef MAXPOOL_PACKER_WCOUNT_EN
   logic [31:0] r_run, r_pend, r_words;
   logic [32:0] w_run_sum;
   logic [31:0] w_run_sat;

   assign w_run_sum = {1'b0, r_run} + 33'(w_pc);
   assign w_run_sat = w_run_sum[32] ? 32'hFFFF_FFFF : w_run_sum[31:0];

   // r_pend holds the finished packet's total until its m_last beat leaves.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_run   <= '0;
         r_pend  <= '0;
         r_words <= '0;
      end else if (clken) begin
         if (w_accept) begin
            if (s_last) begin
               r_pend <= w_run_sat;
               r_run  <= '0;
            end else begin
               r_run  <= w_run_sat;
            end
         end
         if (w_out_hs && r_m_last)
            r_words <= r_pend;
      end
   end

   assign m_packet_words = r_words;
`endif

   assign s_ready     = w_s_ready;
   assign m_valid     = r_m_valid;
   assign m_data_flat = r_m_data;
   assign m_keep_flat = r_m_keep;
   assign m_last      = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_output_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_output_packer
// Brief    : Scoreboard bench for maxpool_output_packer (N=8, 8-bit words).
// Revision : 1.0
// ============================================================================
module tb_maxpool_output_packer;

   localparam int N = 8;
   localparam int W = 8;

   logic           clk     = 1'b0;
   logic           resetn  = 1'b0;
   logic           clken   = 1'b1;
   logic           s_valid = 1'b0;
   logic           s_last  = 1'b0;
   logic           m_ready = 1'b1;
   logic [N*W-1:0] s_data  = '0;
   logic [N-1:0]   s_keep  = '0;
   logic           s_ready, m_valid, m_last;
   logic [N*W-1:0] m_data;
   logic [N-1:0]   m_keep;
`ifdef MAXPOOL_PACKER_WCOUNT_EN
   logic [31:0]    m_words;
`endif

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] mq[$];
   int         n_checks = 0;
   int         n_errors = 0;
   bit         rnd_mode = 1'b0;

   always #5 clk = ~clk;

   maxpool_output_packer #(
      .UNITS      (2),
      .GROUPS     (2),
      .WORD_WIDTH (W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .clken       (clken),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data_flat (s_data),
      .s_keep_flat (s_keep),
      .s_last      (s_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data_flat (m_data),
      .m_keep_flat (m_keep),
`ifdef MAXPOOL_PACKER_WCOUNT_EN
      .m_packet_words (m_words),
`endif
      .m_last      (m_last)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: a plain word FIFO per packet, cut into 8-word beats.
   task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
      beat_t b;
      bit    done_last;
      done_last = 1'b0;
      for (int i = 0; i < 8; i++)
         if (k[i]) mq.push_back(d[i*8 +: 8]);
      if (mq.size() >= 8) begin
         b.d = '0;
         for (int i = 0; i < 8; i++) b.d[i*8 +: 8] = mq.pop_front();
         b.k = 8'hFF;
         b.l = l && (mq.size() == 0);
         done_last = b.l;
         exp_q.push_back(b);
      end
      if (l && !done_last) begin
         b.d = '0;
         b.k = '0;
         for (int i = 0; mq.size() > 0; i++) begin
            b.d[i*8 +: 8] = mq.pop_front();
            b.k[i] = 1'b1;
         end
         b.l = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (resetn && m_valid && m_ready && clken) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_keep", {56'd0, m_keep}, {56'd0, e.k});
            chk("beat_last", {63'd0, m_last}, {63'd0, e.l});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode) begin
         m_ready = ($urandom_range(0, 1) == 1);
         clken   = ($urandom_range(0, 5) != 0);
      end
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit acc;
      acc     = 1'b0;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_valid = 1'b1;
      for (int c = 0; c < 200 && !acc; c++) begin
         @(negedge clk);
         if (s_ready && clken) begin
            acc = 1'b1;
            model_accept(d, k, l);
         end
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [63:0] seq(input logic [7:0] base);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = base + 8'(i);
      return r;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_last",  {63'd0, m_last},  64'd0);
      chk("rst_keep",  {56'd0, m_keep},  64'd0);
      chk("rst_data",  m_data,           64'd0);
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {63'd0, s_ready}, 64'd1);
      tick();

      // Full beat with last, one-cycle latency
      send(seq(8'h01), 8'hFF, 1'b1);
      chk("latency_valid", {63'd0, m_valid}, 64'd1);
      drain();

      // Two interleaved keep patterns completing one beat
      send(seq(8'h11), 8'b1010_0101, 1'b0);
      send(seq(8'h21), 8'b0101_1010, 1'b1);
      drain();

      // Overflow on last: full beat then tail beat, s_ready low in FLUSH
      send(seq(8'h31), 8'h0F, 1'b0);
      send(seq(8'h41), 8'hFF, 1'b1);
      @(negedge clk);
      chk("ready_low_flush", {63'd0, s_ready}, 64'd0);
      drain();

      // Empty last beat
      send(seq(8'h00), 8'h00, 1'b1);
      drain();

      // Backpressure: outputs frozen, input blocked
      m_ready = 1'b0;
      send(seq(8'h51), 8'hFF, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid", {63'd0, m_valid}, 64'd1);
         chk("stall_data",  m_data, seq(8'h51));
         chk("stall_ready", {63'd0, s_ready}, 64'd0);
      end
      m_ready = 1'b1;
      drain();

      // Random traffic with random backpressure and clock enable
      rnd_mode = 1'b1;
      for (int b = 0; b < 40; b++)
         send({$urandom, $urandom}, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      send({$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b1);
      rnd_mode = 1'b0;
      m_ready  = 1'b1;
      clken    = 1'b1;
      drain();

      // Reset mid-packet with a stalled output beat and held words
      send(seq(8'h61), 8'h0F, 1'b0);
      m_ready = 1'b0;
      send(seq(8'h71), 8'hFF, 1'b0);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("reset_clears_valid", {63'd0, m_valid}, 64'd0);
      chk("reset_clears_keep",  {56'd0, m_keep},  64'd0);
      exp_q.delete();
      mq.delete();
      @(posedge clk);
      #1 resetn = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", {63'd0, s_ready}, 64'd1);
      tick();
      send(seq(8'h81), 8'hFF, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
